// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the EX stage.
// The full result is computed when the command is accepted and held
// internally. It commits to HI/LO after a fixed latency. Busy stays high for
// that whole latency so that hazard logic can stall HI/LO consumers.
module muldiv_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  ctrl,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [2:0] CMD_MULT  = 3'd1;
  localparam logic [2:0] CMD_MULTU = 3'd2;
  localparam logic [2:0] CMD_DIV   = 3'd3;
  localparam logic [2:0] CMD_DIVU  = 3'd4;
  localparam logic [2:0] CMD_MTHI  = 3'd5;
  localparam logic [2:0] CMD_MTLO  = 3'd6;

  localparam logic [4:0] MULT_LOAD = 5'(MULT_CYCLES - 1);
  localparam logic [4:0] DIV_LOAD  = 5'(DIV_CYCLES - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] res_q, res_d;   // pending {hi, lo}
  logic        wr_q, wr_d;     // pending result is valid (cleared on divide by zero)
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        is_idle;
  logic        acc_long;
  logic        acc_mthi;
  logic        acc_mtlo;
  logic        commit;

  // Signed divide returning {remainder, quotient}. The most-negative / -1
  // overflow is handled explicitly so the result does not depend on how the
  // tool treats overflow, and a zero divisor returns zero rather than X.
  function automatic logic [63:0] div_signed(input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] q;
    logic signed [31:0] r;
    if (b == 32'd0) begin
      q = '0;
      r = '0;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'sh8000_0000;
      r = '0;
    end else begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end
    return {r, q};
  endfunction

  // Unsigned divide returning {remainder, quotient}; a zero divisor returns zero.
  function automatic logic [63:0] div_unsigned(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q;
    logic [31:0] r;
    if (b == 32'd0) begin
      q = '0;
      r = '0;
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  assign is_idle  = (state_q == IDLE);
  assign acc_long = is_idle && start && (ctrl >= CMD_MULT) && (ctrl <= CMD_DIVU);
  assign acc_mthi = is_idle && start && (ctrl == CMD_MTHI);
  assign acc_mtlo = is_idle && start && (ctrl == CMD_MTLO);

  // Next-state logic: leave IDLE on an accepted multiply/divide, return when the counter expires.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (acc_long) state_d = RUN;
      RUN:     if (cnt_q == 5'd0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs decoded from the state register only.
  always_comb begin
    busy   = (state_q == RUN);
    commit = (state_q == RUN) && (cnt_q == 5'd0);
  end

  // Compute the result and the latency at acceptance, and count down while running.
  always_comb begin
    cnt_d = cnt_q;
    res_d = res_q;
    wr_d  = wr_q;
    if (acc_long) begin
      case (ctrl)
        CMD_MULT: begin
          res_d = {{32{A[31]}}, A} * {{32{B[31]}}, B};
          wr_d  = 1'b1;
          cnt_d = MULT_LOAD;
        end
        CMD_MULTU: begin
          res_d = {32'd0, A} * {32'd0, B};
          wr_d  = 1'b1;
          cnt_d = MULT_LOAD;
        end
        CMD_DIV: begin
          res_d = div_signed(A, B);
          wr_d  = (B != 32'd0);
          cnt_d = DIV_LOAD;
        end
        default: begin
          res_d = div_unsigned(A, B);
          wr_d  = (B != 32'd0);
          cnt_d = DIV_LOAD;
        end
      endcase
    end else if (busy && cnt_q != 5'd0) begin
      cnt_d = cnt_q - 5'd1;
    end
  end

  // HI/LO update: a move writes them at once, a multiply/divide writes them at commit.
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (commit && wr_q) begin
      hi_d = res_q[63:32];
      lo_d = res_q[31:0];
    end else if (acc_mthi) begin
      hi_d = A;
    end else if (acc_mtlo) begin
      lo_d = A;
    end
  end

  // State register; reset clears everything, aborting any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      res_q   <= '0;
      wr_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      wr_q    <= wr_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed, table-driven bench for muldiv_unit, with hand-written sequences
// for reset, commands ignored while busy, and abort on reset.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  ctrl;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_chk  = 0;
  int n_fail = 0;

  muldiv_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .ctrl  (ctrl),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  c;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one command right now (called just after a rising edge), follow it
  // through busy, and optionally inject an MTHI 0xDEAD at busy cycle 'inject'.
  task automatic run_op(input string name, input logic [2:0] c, input logic [31:0] a,
                        input logic [31:0] b, input int inject, output int cyc);
    logic [31:0] h0, l0;
    start = 1'b1; ctrl = c; A = a; B = b;
    @(posedge clk); #1;
    start = 1'b0; ctrl = 3'd0;
    h0 = hi; l0 = lo; cyc = 0;
    while (busy && cyc < 40) begin
      chk({name, " hi held"}, hi, h0);
      chk({name, " lo held"}, lo, l0);
      if (cyc == inject) begin
        start = 1'b1; ctrl = 3'd5; A = 32'hDEAD;
      end else begin
        start = 1'b0; ctrl = 3'd0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0; ctrl = 3'd0;
  endtask

  initial begin
    int cyc;
    reset = 1'b1; start = 1'b1; ctrl = 3'd1; A = 32'hFFFF_FFFE; B = 32'd3;

    // Reset held two cycles with a MULT presented: no effect.
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset hi", hi, 32'd0);
    chk("reset lo", lo, 32'd0);
    reset = 1'b0; start = 1'b0; ctrl = 3'd0;
    @(posedge clk); #1;
    chk("post-reset busy", {31'd0, busy}, 32'd0);
    chk("post-reset hi", hi, 32'd0);

    vecs[0]  = '{3'd1, 32'hFFFF_FFFE, 32'd3,          32'hFFFF_FFFF, 32'hFFFF_FFFA, 5};
    vecs[1]  = '{3'd2, 32'hFFFF_FFFE, 32'd3,          32'h0000_0002, 32'hFFFF_FFFA, 5};
    vecs[2]  = '{3'd1, 32'h7FFF_FFFF, 32'h7FFF_FFFF,  32'h3FFF_FFFF, 32'h0000_0001, 5};
    vecs[3]  = '{3'd3, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
    vecs[4]  = '{3'd3, 32'd7,         32'hFFFF_FFFE,  32'h0000_0001, 32'hFFFF_FFFD, 10};
    vecs[5]  = '{3'd3, 32'h8000_0000, 32'hFFFF_FFFF,  32'h0000_0000, 32'h8000_0000, 10};
    vecs[6]  = '{3'd4, 32'hFFFF_FFFF, 32'h10,         32'h0000_000F, 32'h0FFF_FFFF, 10};
    vecs[7]  = '{3'd5, 32'h1234,      32'd0,          32'h0000_1234, 32'h0FFF_FFFF, 0};
    vecs[8]  = '{3'd6, 32'h5678,      32'd0,          32'h0000_1234, 32'h0000_5678, 0};
    vecs[9]  = '{3'd2, 32'd6,         32'd7,          32'h0000_0000, 32'd42,        5};
    vecs[10] = '{3'd4, 32'd100,       32'd7,          32'h0000_0002, 32'd14,        10};
    vecs[11] = '{3'd7, 32'hDEAD,      32'hBEEF,       32'h0000_0002, 32'd14,        0};

    // Commands issued back to back at the earliest legal cycle.
    for (int i = 0; i < 12; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].c, vecs[i].a, vecs[i].b, -1, cyc);
      chk($sformatf("vec%0d busy cycles", i), 32'(cyc), 32'(vecs[i].cyc));
      chk($sformatf("vec%0d hi", i), hi, vecs[i].hi);
      chk($sformatf("vec%0d lo", i), lo, vecs[i].lo);
    end

    // Preload, then divide by zero with an MTHI presented while busy.
    run_op("mthi", 3'd5, 32'h1234, 32'd0, -1, cyc);
    run_op("mtlo", 3'd6, 32'h5678, 32'd0, -1, cyc);
    chk("mt busy cycles", 32'(cyc), 32'd0);
    chk("mt hi", hi, 32'h1234);
    chk("mt lo", lo, 32'h5678);
    run_op("divu0", 3'd4, 32'd55, 32'd0, 3, cyc);
    chk("divu0 busy cycles", 32'(cyc), 32'd10);
    chk("divu0 hi", hi, 32'h1234);
    chk("divu0 lo", lo, 32'h5678);
    @(posedge clk); #1;
    chk("divu0 after hi", hi, 32'h1234);
    chk("divu0 after busy", {31'd0, busy}, 32'd0);

    // Reset at busy cycle 4 of a DIVU aborts it.
    start = 1'b1; ctrl = 3'd4; A = 32'd100; B = 32'd7;
    @(posedge clk); #1;
    start = 1'b0; ctrl = 3'd0;
    chk("abort busy start", {31'd0, busy}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("abort still busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort busy", {31'd0, busy}, 32'd0);
    chk("abort hi", hi, 32'd0);
    chk("abort lo", lo, 32'd0);
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
      chk("abort idle busy", {31'd0, busy}, 32'd0);
      chk("abort idle hi", hi, 32'd0);
      chk("abort idle lo", lo, 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Multi-cycle multiply/divide unit with HI/LO registers, sitting beside the ALU in the EX stage. It executes MULT, MULTU, DIV, DIVU, MTHI and MTLO. It sequences each operation with a latency counter and raises busy so hazard logic can stall later HI/LO consumers. MFHI/MFLO read the hi/lo outputs directly.

Parameters:
MULT_CYCLES, 5, cycles busy is high for MULT/MULTU (legal range 1..31)
DIV_CYCLES, 10, cycles busy is high for DIV/DIVU (legal range 1..31)

Ports:
clk  input  1  system clock, all state updates on the rising edge
reset  input  1  synchronous, active-high; clears all state
start  input  1  command valid this cycle
ctrl  input  3  command: 0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as none)
A  input  32  rs operand (multiplicand / dividend / MT source)
B  input  32  rt operand (multiplier / divisor)
busy  output  1  operation in flight
hi  output  32  HI register
lo  output  32  LO register

Behaviour:
- Reset: busy=0, hi=0, lo=0, counter=0, pending result cleared. Reset dominates any other input in the same cycle. Reset mid-operation aborts the operation: the result is never committed.
- State machine: IDLE / RUN.
- Command acceptance: in IDLE, start=1 with ctrl in 1..6 is accepted at that edge. In RUN, start is ignored entirely (no queueing, no effect on hi/lo). Upstream must stall on busy.
- Stall contract: the hazard unit stalls an MFHI/MFLO or muldiv instruction when (start & ctrl in 1..4) | busy.
- MTHI/MTLO: hi<=A or lo<=A at the accepting edge. No busy, no RUN.
- MULT/MULTU/DIV/DIVU, accepted at edge E0:
  - Operands are captured, or the result is computed and held internally, at E0.
  - RUN is entered and busy=1 from E0 for exactly N cycles (N = MULT_CYCLES or DIV_CYCLES).
  - At edge E0+N: hi/lo commit, busy<=0, return to IDLE.
  - A new command may be accepted at the cycle after busy falls (edge E0+N+1 at the earliest).
  - hi/lo hold their old values for the whole of RUN.
- Counter: loaded with N-1 at E0, decremented each RUN cycle. Commit when it reads 0.
- MULT: {hi,lo} = signed(A) * signed(B), 64-bit.
- MULTU: {hi,lo} = A * B, unsigned, 64-bit.
- DIV: lo = quotient truncated toward zero, hi = remainder with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- DIVU: lo = A / B, hi = A % B, unsigned.
- Divide by zero (B==0, DIV or DIVU): full DIV_CYCLES busy, then hi/lo unchanged at commit. Never X.
- Outputs are registered only. No combinational path from inputs to busy/hi/lo.

Test Plan:
- Reset then idle: reset held 2 cycles -> busy=0, hi=0, lo=0; start=1 ctrl=1 asserted during reset -> no effect.
- MULT signed: A=0xFFFFFFFE, B=3, start one cycle -> busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA; hi/lo unchanged while busy. MULTU same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV signed: A=-7 (0xFFFFFFF9), B=2 -> busy 10 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF. Overflow case A=0x80000000, B=0xFFFFFFFF -> lo=0x80000000, hi=0.
- Divide by zero and ignored commands:
  - Preload with MTHI A=0x1234, then MTLO A=0x5678 -> hi=0x1234, lo=0x5678, busy never set.
  - DIVU B=0 -> busy 10 cycles, then hi=0x1234, lo=0x5678.
  - During that busy, start=1 ctrl=5 A=0xDEAD -> ignored.
- Back-to-back: MULTU 6*7 and DIVU 100/7 issued at the earliest legal cycles -> first: lo=42, hi=0; second accepted the cycle after busy falls; final lo=14, hi=2.
- Reset mid-operation: DIVU 100/7 started, reset at busy cycle 4 -> busy=0, hi=lo=0 next cycle; no later commit observed over 15 cycles.
